// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the two-source UDP transmit arbiter.
package udp_tx_arb_pkg;

  localparam int unsigned LEN_W       = 16;
  localparam int unsigned DEF_MAX_LEN = 1472;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    XFER,
    DONE
  } state_t;

  // A zero-length frame is as unusable to eth as an oversize one.
  function automatic logic len_valid(input logic [LEN_W-1:0] len,
                                     input int unsigned      max_len);
    return (len != '0) && ({16'h0, len} <= max_len);
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_arb2.sv
// Two-way round-robin picker: pri selects the winner only when both request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pri,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = en && (req != 2'b00);
    gnt_id    = (req == 2'b11) ? pri : req[1];
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares the eth UDP transmit path between src0/src1, one frame per grant.
// Optional watchdog on the eth handshake: define UDP_TX_ARB_WDT_EN.
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src0_req,
  input  logic [LEN_W-1:0] src0_len,
  output logic             src0_ack,
  output logic             src0_rd,
  input  logic [7:0]       src0_data,
  output logic             src0_done,
  input  logic             src1_req,
  input  logic [LEN_W-1:0] src1_len,
  output logic             src1_ack,
  output logic             src1_rd,
  input  logic [7:0]       src1_data,
  output logic             src1_done,
  input  logic             tx_rdy,
  output logic             udp_tx_en,
  output logic [LEN_W-1:0] udp_tx_data_num,
  input  logic             udp_tx_req,
  output logic [7:0]       udp_tx_data,
  output logic             grant_id,
  output logic             busy,
  output logic             err
);

  state_t           state, state_nx;
  logic             rr_pri, gid, data_vld;
  logic [LEN_W-1:0] len_q, cnt, sel_len;
  logic             gnt_valid, gnt_id, arb_en;
  logic [1:0]       ack, rd, done;
  logic             last, rr_load, wdt_abort;

  assign arb_en  = (state == IDLE) && tx_rdy && !rst;
  assign sel_len = gnt_id ? src1_len : src0_len;
  assign last    = udp_tx_req && ((cnt + 16'd1) == len_q);

  rr_arb2 u_rr_arb2 (
    .req       ({src1_req, src0_req}),
    .pri       (rr_pri),
    .en        (arb_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef UDP_TX_ARB_WDT_EN
  logic [15:0] wdt;
  logic        wdt_run;

  assign wdt_run   = (state == WAIT_BUSY) || (state == XFER);
  assign wdt_abort = wdt_run && !udp_tx_req && ((state == XFER) || tx_rdy) &&
                     (wdt == 16'(WDT_CYCLES - 1));

  // Restarts on every state change and every eth byte request.
  always_ff @(posedge clk) begin
    if (rst || !wdt_run || udp_tx_req || (state_nx != state)) wdt <= '0;
    else                                                      wdt <= wdt + 16'd1;
  end
`else
  assign wdt_abort = (WDT_CYCLES == 0) && 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    ack       = '0;
    rd        = '0;
    done      = '0;
    udp_tx_en = 1'b0;
    err       = 1'b0;
    rr_load   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (len_valid(sel_len, MAX_LEN)) begin
            state_nx = START;
          end else begin
            ack[gnt_id] = 1'b1;
            err         = 1'b1;
          end
        end
      end
      START: begin
        udp_tx_en = 1'b1;
        ack[gid]  = 1'b1;
        state_nx  = WAIT_BUSY;
      end
      // Requests racing the tx_rdy fall are served and counted here too.
      WAIT_BUSY, XFER: begin
        rd[gid] = udp_tx_req;
        if (last) begin
          state_nx = DONE;
        end else if (wdt_abort) begin
          err      = 1'b1;
          rr_load  = 1'b1;
          state_nx = IDLE;
        end else if ((state == WAIT_BUSY) && !tx_rdy) begin
          state_nx = XFER;
        end
      end
      DONE: begin
        if (tx_rdy) begin
          done[gid] = 1'b1;
          rr_load   = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_pri   <= 1'b0;
      gid      <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      data_vld <= 1'b0;
    end else begin
      state    <= state_nx;
      data_vld <= |rd;
      if (gnt_valid) begin
        gid   <= gnt_id;
        len_q <= sel_len;
      end
      if (state == START) cnt <= '0;
      else if (|rd)       cnt <= cnt + 16'd1;
      if (rr_load) rr_pri <= ~gid;
    end
  end

  // Byte returns the cycle after its rd, so the mux follows the rd pipeline, not the state.
  assign udp_tx_data     = data_vld ? (gid ? src1_data : src0_data) : '0;
  assign udp_tx_data_num = (state != IDLE) ? len_q : '0;
  assign grant_id        = gid;
  assign busy            = (state != IDLE);
  assign src0_ack        = ack[0];
  assign src1_ack        = ack[1];
  assign src0_rd         = rd[0];
  assign src1_rd         = rd[1];
  assign src0_done       = done[0];
  assign src1_done       = done[1];

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: stimulus queues expected events, a monitor pops them.
module tb_udp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src0_req = 1'b0, src1_req = 1'b0;
  logic [15:0] src0_len = '0, src1_len = '0;
  logic        src0_ack, src1_ack, src0_rd, src1_rd, src0_done, src1_done;
  logic [7:0]  src0_data = '0, src1_data = '0;
  logic        tx_rdy = 1'b1;
  logic        udp_tx_en;
  logic [15:0] udp_tx_data_num;
  logic        udp_tx_req = 1'b0;
  logic [7:0]  udp_tx_data;
  logic        grant_id, busy, err;

  udp_tx_arbiter #(.MAX_LEN(1472), .WDT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .src0_req(src0_req), .src0_len(src0_len), .src0_ack(src0_ack), .src0_rd(src0_rd),
    .src0_data(src0_data), .src0_done(src0_done),
    .src1_req(src1_req), .src1_len(src1_len), .src1_ack(src1_ack), .src1_rd(src1_rd),
    .src1_data(src1_data), .src1_done(src1_done),
    .tx_rdy(tx_rdy), .udp_tx_en(udp_tx_en), .udp_tx_data_num(udp_tx_data_num),
    .udp_tx_req(udp_tx_req), .udp_tx_data(udp_tx_data),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_ACK, EV_START, EV_BYTE, EV_DONE} ev_k_t;
  typedef struct {
    ev_k_t       kind;
    logic        id;
    logic [15:0] val;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  pend0 = 0, pend1 = 0;
  int  sq0 = 0, sq1 = 0;
  logic owner = 1'b0;
  logic req_live = 1'b0;
  logic wdt_err_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ev_k_t k, input logic id, input logic [15:0] v);
    ev_t e;
    e.kind = k; e.id = id; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic push_frame(input logic id, input int len);
    push(EV_ACK, id, 16'd0);
    push(EV_START, id, 16'(len));
    for (int i = 0; i < len; i++) push(EV_BYTE, id, 16'((id ? 8'hB0 : 8'hA0) + i));
    push(EV_DONE, id, 16'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ctl"}, {src0_ack, src1_ack, src0_rd, src1_rd, src0_done, src1_done,
                        udp_tx_en, grant_id, busy, err}, 32'd0);
    chk({tag, "_num"}, udp_tx_data_num, 32'd0);
    chk({tag, "_data"}, udp_tx_data, 32'd0);
  endtask

  task automatic wait_start(output bit ok);
    int t = 0;
    while (!udp_tx_en && t < 200) begin step(); t++; end
    ok = udp_tx_en;
    if (!ok) chk("start_timeout", 32'd0, 32'd1);
  endtask

  // eth model: drop tx_rdy 2 cycles after udp_tx_en, issue n reqs, one stray req in DONE.
  task automatic eth_run(input logic id, input int n, input bit same_cycle);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    owner = id;
    step(); step();
    tx_rdy = 1'b0;
    if (!same_cycle) step();
    req_live = 1'b1;
    repeat (n) begin udp_tx_req = 1'b1; step(); end
    req_live = 1'b0;
    udp_tx_req = 1'b1;
    step();
    udp_tx_req = 1'b0;
    chk("stray_done_data", udp_tx_data, 32'd0);
    tx_rdy = 1'b1;
    step();
  endtask

  task automatic wait_pend_clear();
    int t = 0;
    while ((pend0 != 0 || pend1 != 0) && t < 50) begin step(); t++; end
    chk("ack_timeout", 32'(pend0 + pend1), 32'd0);
  endtask

  // Source model: holds req while frames are pending, serves bytes one cycle after rd.
  initial begin
    logic a0, a1, r0, r1;
    forever begin
      @(posedge clk);
      a0 = src0_ack; a1 = src1_ack; r0 = src0_rd; r1 = src1_rd;
      #1;
      if (a0) begin pend0--; sq0 = 0; end
      if (a1) begin pend1--; sq1 = 0; end
      if (r0) begin src0_data = 8'(8'hA0 + sq0); sq0++; end
      if (r1) begin src1_data = 8'(8'hB0 + sq1); sq1++; end
      src0_req = (pend0 > 0);
      src1_req = (pend1 > 0);
    end
  end

  initial begin
    ev_t  e;
    logic prev_rd = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (src0_ack || src1_ack) begin
        if (sbq.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("ack_kind", 32'(e.kind), 32'(EV_ACK));
          chk("ack_id", {src1_ack, src0_ack}, e.id ? 32'd2 : 32'd1);
          chk("ack_err", err, e.val[0]);
        end
      end else if (err && !wdt_err_ok) chk("err_spurious", err, 32'd0);
      if (udp_tx_en) begin
        if (sbq.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("start_kind", 32'(e.kind), 32'(EV_START));
          chk("start_grant", grant_id, e.id);
          chk("start_num", udp_tx_data_num, e.val);
        end
      end
      if (prev_rd) begin
        if (sbq.size() == 0) chk("byte_unexpected", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("byte_kind", 32'(e.kind), 32'(EV_BYTE));
          chk("byte_data", udp_tx_data, e.val);
        end
      end
      if (src0_done || src1_done) begin
        if (sbq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("done_kind", 32'(e.kind), 32'(EV_DONE));
          chk("done_id", {src1_done, src0_done}, e.id ? 32'd2 : 32'd1);
          chk("done_rdy", tx_rdy, 32'd1);
        end
      end
      if (udp_tx_req) begin
        chk("rd0", src0_rd, req_live && (owner == 1'b0));
        chk("rd1", src1_rd, req_live && (owner == 1'b1));
      end
      prev_rd = src0_rd | src1_rd;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (3) step();
    rst = 1'b0;
    check_idle_zero("reset");

    // Both sources busy, len 8 each: grants alternate starting with src0.
    src0_len = 16'd8; src1_len = 16'd8;
    push_frame(1'b0, 8); push_frame(1'b1, 8); push_frame(1'b0, 8); push_frame(1'b1, 8);
    pend0 = 2; pend1 = 2;
    eth_run(1'b0, 8, 1'b0);
    eth_run(1'b1, 8, 1'b0);
    eth_run(1'b0, 8, 1'b0);
    eth_run(1'b1, 8, 1'b0);

    // src0 alone, len 4, then a stray req in IDLE.
    src0_len = 16'd4;
    push_frame(1'b0, 4);
    pend0 = 1;
    eth_run(1'b0, 4, 1'b0);
    udp_tx_req = 1'b1;
    step();
    udp_tx_req = 1'b0;
    chk("stray_idle_data", udp_tx_data, 32'd0);

    // Rejected lengths leave rr_pri at 1, so src1 wins the following tie.
    src1_len = 16'd0;
    push(EV_ACK, 1'b1, 16'd1);
    pend1 = 1;
    wait_pend_clear();
    src1_len = 16'd1473;
    push(EV_ACK, 1'b1, 16'd1);
    pend1 = 1;
    wait_pend_clear();
    src0_len = 16'd1; src1_len = 16'd2;
    push_frame(1'b1, 2); push_frame(1'b0, 1);
    pend0 = 1; pend1 = 1;
    eth_run(1'b1, 2, 1'b0);
    eth_run(1'b0, 1, 1'b0);

    // Single byte whose req coincides with tx_rdy falling.
    src0_len = 16'd1;
    push_frame(1'b0, 1);
    pend0 = 1;
    eth_run(1'b0, 1, 1'b1);

    // Reset after 3 of 10 bytes; no restart while tx_rdy stays low.
    src0_len = 16'd10;
    push(EV_ACK, 1'b0, 16'd0); push(EV_START, 1'b0, 16'd10);
    for (int i = 0; i < 3; i++) push(EV_BYTE, 1'b0, 16'(8'hA0 + i));
    pend0 = 1;
    wait_start(ok);
    step(); step();
    tx_rdy = 1'b0;
    step();
    owner = 1'b0; req_live = 1'b1;
    repeat (3) begin udp_tx_req = 1'b1; step(); end
    udp_tx_req = 1'b0; req_live = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("midframe_reset");
    src0_len = 16'd2;
    pend0 = 1;
    repeat (5) step();
    chk("hold_busy", busy, 32'd0);
    chk("hold_en", udp_tx_en, 32'd0);
    push_frame(1'b0, 2);
    tx_rdy = 1'b1;
    eth_run(1'b0, 2, 1'b0);

    // eth never drops tx_rdy after the start pulse.
    src0_len = 16'd5;
    push(EV_ACK, 1'b0, 16'd0); push(EV_START, 1'b0, 16'd5);
    pend0 = 1;
    wait_start(ok);
`ifdef UDP_TX_ARB_WDT_EN
    begin
      int k = 0;
      wdt_err_ok = 1'b1;
      step(); k = 1;
      while (!err && k < 40) begin step(); k++; end
      chk("wdt_err_cycle", 32'(k), 32'd16);
      step();
      wdt_err_ok = 1'b0;
      chk("wdt_busy", busy, 32'd0);
    end
`else
    repeat (1000) step();
    chk("no_wdt_busy", busy, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("no_wdt_reset");
`endif

    repeat (5) step();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path of the eth core between two user data sources (src0, src1).
- Round-robin grant per frame; drives udp_tx_en/udp_tx_data_num, routes udp_tx_req to the granted source, muxes its data back, and tracks frame completion via tx_rdy.
- Sits between user logic and eth, in the gmii_tx_clk domain.

Parameters:
- MAX_LEN, 1472, largest legal UDP payload in bytes; longer requests are rejected.
- WDT_CYCLES, 1024, cycles allowed for tx_rdy to fall after udp_tx_en (used only with the optional feature).

Ports:
- clk  in  1  transmit clock (gmii_tx_clk).
- rst  in  1  synchronous reset, active-high.
- srcN_req  in  1  source N (N=0,1) has a frame pending; level, held until srcN_ack.
- srcN_len  in  16  payload byte count for source N; stable while srcN_req=1.
- srcN_ack  out  1  one-cycle pulse: frame accepted (or rejected, see err).
- srcN_rd  out  1  byte request to source N (forwarded udp_tx_req).
- srcN_data  in  8  source N byte; valid one cycle after srcN_rd.
- srcN_done  out  1  one-cycle pulse: frame fully handed to eth.
- tx_rdy  in  1  eth transmitter idle when high.
- udp_tx_en  out  1  one-cycle start pulse to eth.
- udp_tx_data_num  out  16  frame length to eth; held from udp_tx_en through the end of the frame.
- udp_tx_req  in  1  eth byte request.
- udp_tx_data  out  8  byte to eth; lags udp_tx_req by one cycle.
- grant_id  out  1  source currently owning the path.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on rejected length or watchdog abort.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_pri=0 (src0 preferred).
- IDLE:
  - Arbitration runs only when tx_rdy=1 and at least one srcN_req=1.
  - If both request, the source equal to rr_pri wins; otherwise the sole requester wins.
  - On a win, register grant_id and latch len.
  - If len=0 or len>MAX_LEN: pulse srcN_ack and err, and stay in IDLE. rr_pri is not updated.
  - Otherwise go to START.
- START (1 cycle):
  - udp_tx_en=1, udp_tx_data_num=latched len, srcN_ack=1 for the granted source.
  - Clear the byte counter cnt (16 bit). Go to WAIT_BUSY.
- WAIT_BUSY: stay until tx_rdy=0, then go to XFER. A udp_tx_req arriving in this state is counted as in XFER.
- XFER:
  - srcN_rd = udp_tx_req for the granted source only; the other source's rd is held 0.
  - udp_tx_data = srcN_data of the granted source, combinational mux on grant_id (zero added latency).
  - cnt increments on each udp_tx_req.
  - When cnt reaches len (last req seen), go to DONE.
- DONE:
  - Wait for tx_rdy=1.
  - Then pulse srcN_done, set rr_pri = ~grant_id, and return to IDLE.
  - The earliest next udp_tx_en comes 2 cycles after tx_rdy rises.
- Extra udp_tx_req in DONE/IDLE: ignored, srcN_rd stays 0, udp_tx_data=0.
- grant_id and udp_tx_data_num are constant from START until the return to IDLE.
- A source deasserting req after ack has no effect on the frame in progress.
- Reset mid-frame: immediate return to IDLE, all outputs 0. eth is re-entered only after tx_rdy=1.

Optional Feature:
- Macro: UDP_TX_ARB_WDT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in WAIT_BUSY.
  - If it reaches WDT_CYCLES with tx_rdy still 1: pulse err, go to IDLE, no srcN_done, rr_pri = ~grant_id.
  - The same watchdog restarts on each udp_tx_req in XFER and aborts identically if WDT_CYCLES pass with no req.
- Undefined: no watchdog logic; WAIT_BUSY and XFER wait indefinitely.

Decomposition:
- Package udp_tx_arb_pkg: state encoding (IDLE, START, WAIT_BUSY, XFER, DONE), LEN_W=16, default MAX_LEN.
- One natural sub-module, rr_arb2: the 2-way round-robin picker.
  - Inputs: req[1:0], pri, en.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- src0 only, len=4, eth model drops tx_rdy 2 cycles after udp_tx_en and issues 4 reqs → udp_tx_en once with num=4; src0_rd mirrors req; udp_tx_data equals src0 bytes 0xA0..0xA3, each one cycle late; src0_done after tx_rdy rises.
- src0 and src1 both requesting continuously, len=8 each → grants alternate 0,1,0,1 over 4 frames; src1_rd stays 0 during src0 frames and vice versa.
- src1_len=0, then src1_len=1473 → each gives src1_ack and err pulses, no udp_tx_en, rr_pri unchanged; a following src0 len=1 completes normally.
- rst asserted during XFER after 3 of 10 bytes → next cycle all outputs 0, state IDLE; a new frame starts only after tx_rdy=1.
- With UDP_TX_ARB_WDT_EN and WDT_CYCLES=16, tx_rdy held 1 after udp_tx_en → err at cycle 16 of WAIT_BUSY, no done, busy=0; without the macro the block is still busy after 1000 cycles.
- Single-byte frame, len=1, udp_tx_req arriving in the same cycle tx_rdy falls → counted, DONE reached, src0_done after tx_rdy rises.
